lif_neuron_array_tm: RTL

//  Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath.
//  Per-neuron membrane state and refractory counters are held in register arrays.
//  One neuron is updated per accepted input beat, in index order 0..N-1 (one sweep).

---
 rtl/lif_pkg.sv | 22 ++
 rtl/lif_neuron_array_tm_update.sv | 31 +++
 rtl/lif_neuron_array_tm.sv | 105 ++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared widths, the per-neuron update result type and the saturating adder
// used by the LIF neuron array datapath.
package lif_pkg;

  localparam int LIF_W     = 8;
  localparam int LIF_REF_W = 3;

  typedef struct packed {
    logic [LIF_W-1:0]     state;
    logic [LIF_REF_W-1:0] refrac;
    logic                 fire;
  } lif_upd_t;

  // Add at one extra bit and clamp to all-ones on carry-out.
  function automatic logic [LIF_W-1:0] sat_add(input logic [LIF_W-1:0] a,
                                               input logic [LIF_W-1:0] b);
    logic [LIF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LIF_W] ? {LIF_W{1'b1}} : s[LIF_W-1:0];
  endfunction

endpackage

// File: rtl/lif_neuron_array_tm_update.sv
// Combinational leak / integrate / threshold / refractory step for the one
// neuron currently addressed by the array pointer.
module lif_update_unit
  import lif_pkg::*;
(
  input  logic [LIF_W-1:0]     i_state,
  input  logic [LIF_REF_W-1:0] i_refrac,
  input  logic [LIF_W-1:0]     i_cur,
  input  logic [LIF_W-1:0]     i_thresh,
  input  logic [2:0]           i_leak_shift,
  input  logic [LIF_REF_W-1:0] i_cfg_refrac,
  output lif_upd_t             o_upd
);

  logic [LIF_W-1:0] w_sum;

  // A refractory neuron ignores its input and stays clamped at zero.
  always_comb begin
    o_upd = '0;
    w_sum = sat_add(i_state >> i_leak_shift, i_cur);
    if (i_refrac != '0) begin
      o_upd.refrac = i_refrac - 1'b1;
    end else if (w_sum >= i_thresh) begin
      o_upd.fire   = 1'b1;
      o_upd.refrac = i_cfg_refrac;
    end else begin
      o_upd.state  = w_sum;
    end
  end

endmodule

// File: rtl/lif_neuron_array_tm.sv
// Time-multiplexed array of leaky integrate-and-fire neurons: one neuron per
// accepted current beat, spike vector published after every full sweep.
module lif_neuron_array_tm
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int W         = LIF_W,
  parameter int IDX_W     = $clog2(N_NEURONS),
  parameter int REF_W     = LIF_REF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cur_valid,
  output logic                 o_cur_ready,
  input  logic [W-1:0]         i_cur_data,
  input  logic [W-1:0]         i_cfg_thresh,
  input  logic [2:0]           i_cfg_leak_shift,
  input  logic [REF_W-1:0]     i_cfg_refrac,
  output logic                 o_spk_valid,
  input  logic                 i_spk_ready,
  output logic [N_NEURONS-1:0] o_spk_vec,
  output logic [IDX_W-1:0]     o_ptr,
  input  logic [IDX_W-1:0]     i_state_rd_idx,
  output logic [W-1:0]         o_state_rd_data
);

  logic [W-1:0]         r_state  [N_NEURONS];
  logic [REF_W-1:0]     r_refrac [N_NEURONS];
  logic [N_NEURONS-1:0] r_acc;
  logic [IDX_W-1:0]     r_ptr;
  logic [W-1:0]         r_thresh;
  logic [2:0]           r_leak_shift;
  logic [REF_W-1:0]     r_cfg_refrac;
  logic                 r_spk_valid;
  logic [N_NEURONS-1:0] r_spk_vec;

  logic                 w_first;
  logic                 w_wrap;
  logic                 w_accept;
  logic [W-1:0]         w_thresh;
  logic [2:0]           w_leak_shift;
  logic [REF_W-1:0]     w_cfg_refrac;
  lif_upd_t             w_upd;

  assign w_first  = (r_ptr == '0);
  assign w_wrap   = (r_ptr == IDX_W'(N_NEURONS - 1));
  assign o_cur_ready = !(w_wrap && r_spk_valid && !i_spk_ready);
  assign w_accept = i_cur_valid && o_cur_ready;

  // The sweep's first beat already runs with the freshly presented config.
  assign w_thresh     = w_first ? i_cfg_thresh     : r_thresh;
  assign w_leak_shift = w_first ? i_cfg_leak_shift : r_leak_shift;
  assign w_cfg_refrac = w_first ? i_cfg_refrac     : r_cfg_refrac;

  lif_update_unit u_update (
    .i_state      (r_state[r_ptr]),
    .i_refrac     (r_refrac[r_ptr]),
    .i_cur        (i_cur_data),
    .i_thresh     (w_thresh),
    .i_leak_shift (w_leak_shift),
    .i_cfg_refrac (w_cfg_refrac),
    .o_upd        (w_upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_state[k]  <= '0;
        r_refrac[k] <= '0;
      end
      r_acc        <= '0;
      r_ptr        <= '0;
      r_thresh     <= '0;
      r_leak_shift <= '0;
      r_cfg_refrac <= '0;
      r_spk_valid  <= 1'b0;
      r_spk_vec    <= '0;
    end else begin
      if (w_accept) begin
        r_state[r_ptr]  <= w_upd.state;
        r_refrac[r_ptr] <= w_upd.refrac;
        r_acc[r_ptr]    <= w_upd.fire;
        r_ptr           <= w_wrap ? '0 : r_ptr + 1'b1;
        if (w_first) begin
          r_thresh     <= i_cfg_thresh;
          r_leak_shift <= i_cfg_leak_shift;
          r_cfg_refrac <= i_cfg_refrac;
        end
      end
      // A wrap beat reloads the vector even while the old one is being popped.
      if (w_accept && w_wrap) begin
        r_spk_vec   <= {w_upd.fire, r_acc[N_NEURONS-2:0]};
        r_spk_valid <= 1'b1;
      end else if (r_spk_valid && i_spk_ready) begin
        r_spk_valid <= 1'b0;
      end
    end
  end

  assign o_spk_valid     = r_spk_valid;
  assign o_spk_vec       = r_spk_vec;
  assign o_ptr           = r_ptr;
  assign o_state_rd_data = r_state[i_state_rd_idx];

endmodule
